rx_frame_writer: RTL and testbench

Parametrised receive-side frame writer between the 10G MAC AXI-Stream Rx port and the internal frame buffer RAM. It stores each accepted frame's data words after a one-word header slot and fills the header once the frame ends. Only then does it publish the frame by advancing a commit pointer consumed by the 250 MHz DMA engine. Compared with the previous generation it adds:
- a parametrised buffer depth;
- a whole-frame space check at start of frame;
- a max-length guard;
- drop of MAC-flagged bad frames;
- gated write enables;
- a capture timestamp in the header.

---
 rtl/rx_frame_pkg.sv | 41 ++++
 rtl/rx_rdptr_sync.sv | 34 +++
 rtl/rx_frame_writer.sv | 189 ++++++++++++++++++
 tb/tb_rx_frame_writer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_frame_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rx_frame_pkg : states and field offsets for rx_frame_writer   rev 1.0|
// +--------------------------------------------------------------------+
package rx_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_HDR  = 3'd2,
    ST_PUB  = 3'd3,
    ST_DROP = 3'd4
  } state_t;

  localparam int HDR_TS_LSB  = 0;
  localparam int HDR_BC_LSB  = 32;
  localparam int HDR_SRC_LSB = 48;
  localparam int HDR_DST_LSB = 56;

  localparam int TU_BC_LSB   = 0;
  localparam int TU_SRC_LSB  = 16;
  localparam int TU_DST_LSB  = 24;
  localparam int TU_BAD_BIT  = 32;

  function automatic logic [63:0] build_header(
    input logic [7:0]  dst,
    input logic [7:0]  src,
    input logic [15:0] bc,
    input logic [31:0] ts
  );
    logic [63:0] h;
    h = '0;
    h[HDR_DST_LSB +: 8]  = dst;
    h[HDR_SRC_LSB +: 8]  = src;
    h[HDR_BC_LSB  +: 16] = bc;
    h[HDR_TS_LSB  +: 32] = ts;
    return h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_rdptr_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rx_rdptr_sync : strobe-qualified consumer pointer capture     rev 1.0|
// +--------------------------------------------------------------------+
module rx_rdptr_sync #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_addr_updated,
  input  logic [ADDR_W-1:0] commited_rd_address,
  output logic [ADDR_W-1:0] rd_sync
);

  logic [1:0]        upd_sync;
  logic [ADDR_W-1:0] addr_q;

  // The strobe gets one more stage than the bus, so the bus copy has settled when it is used.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      upd_sync <= '0;
      addr_q   <= '0;
      rd_sync  <= '0;
    end else begin
      upd_sync <= {upd_sync[0], rd_addr_updated};
      addr_q   <= commited_rd_address;
      if (upd_sync[1]) begin
        rd_sync <= addr_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rx_frame_writer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rx_frame_writer : AXI-S Rx frames into buffer RAM, header + commit rev 1.0|
// +--------------------------------------------------------------------+
module rx_frame_writer
  import rx_frame_pkg::*;
#(
  parameter int ADDR_W          = 15,
  parameter int MAX_FRAME_WORDS = 1200
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [63:0]       s_axis_tdata,
  input  logic [7:0]        s_axis_tstrb,
  input  logic [127:0]      s_axis_tuser,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [63:0]       wr_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] commited_wr_address,
  input  logic              rd_addr_updated,
  input  logic [ADDR_W-1:0] commited_rd_address,
  output logic [31:0]       committed_frames,
  output logic [31:0]       dropped_frames
);

  localparam int                BEAT_W    = $clog2(MAX_FRAME_WORDS + 1);
  localparam logic [BEAT_W-1:0] MAX_BEATS = BEAT_W'(MAX_FRAME_WORDS);
  localparam logic [31:0]       RESERVE   = 32'(MAX_FRAME_WORDS + 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] aux_addr;
  logic [ADDR_W-1:0] rd_sync;
  logic [ADDR_W-1:0] used, free;
  logic              no_space;
  logic [BEAT_W-1:0] beats;
  logic [31:0]       ts_cnt, ts_frame;
  logic [15:0]       hdr_bc;
  logic [7:0]        hdr_src, hdr_dst;

  logic do_write, do_sof, do_rewind, do_latch, do_drop, do_hdr, do_pub, eof_chk;
  logic unused_bits;

  assign unused_bits = ^{s_axis_tstrb, s_axis_tuser[127:TU_BAD_BIT+1]};

  rx_rdptr_sync #(
    .ADDR_W(ADDR_W)
  ) u_rdptr_sync (
    .clk                 (clk),
    .reset_n             (reset_n),
    .rd_addr_updated     (rd_addr_updated),
    .commited_rd_address (commited_rd_address),
    .rd_sync             (rd_sync)
  );

  // Bitwise inverse of used is exactly 2^ADDR_W - 1 - used.
  assign used     = aux_addr - rd_sync;
  assign free     = ~used;
  assign no_space = ({{(32-ADDR_W){1'b0}}, free} < RESERVE);

  assign s_axis_tready = (state != ST_HDR) && (state != ST_PUB);

  always_comb begin
    state_nxt = state;
    do_write  = 1'b0;
    do_sof    = 1'b0;
    do_rewind = 1'b0;
    do_latch  = 1'b0;
    do_drop   = 1'b0;
    do_hdr    = 1'b0;
    do_pub    = 1'b0;
    eof_chk   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (s_axis_tvalid) begin
          if (no_space) begin
            if (s_axis_tlast) do_drop = 1'b1;
            else              state_nxt = ST_DROP;
          end else begin
            do_write  = 1'b1;
            do_sof    = 1'b1;
            eof_chk   = s_axis_tlast;
            state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (s_axis_tvalid) begin
          if (beats == MAX_BEATS) begin
            do_rewind = 1'b1;
            if (s_axis_tlast) begin
              do_drop   = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              state_nxt = ST_DROP;
            end
          end else begin
            do_write = 1'b1;
            eof_chk  = s_axis_tlast;
          end
        end
      end
      ST_HDR: begin
        do_hdr    = 1'b1;
        state_nxt = ST_PUB;
      end
      ST_PUB: begin
        do_pub    = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_DROP: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          do_drop   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (eof_chk) begin
      if (s_axis_tuser[TU_BAD_BIT]) begin
        do_rewind = 1'b1;
        do_drop   = 1'b1;
        state_nxt = ST_IDLE;
      end else begin
        do_latch  = 1'b1;
        state_nxt = ST_HDR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state               <= ST_IDLE;
      aux_addr            <= ONE;
      commited_wr_address <= '0;
      beats               <= '0;
      ts_cnt              <= '0;
      ts_frame            <= '0;
      hdr_bc              <= '0;
      hdr_src             <= '0;
      hdr_dst             <= '0;
      wr_en               <= 1'b0;
      wr_addr             <= '0;
      wr_data             <= '0;
      committed_frames    <= '0;
      dropped_frames      <= '0;
    end else begin
      state  <= state_nxt;
      ts_cnt <= ts_cnt + 32'd1;
      wr_en  <= do_write | do_hdr;
      if (do_hdr) begin
        wr_addr <= commited_wr_address;
        wr_data <= build_header(hdr_dst, hdr_src, hdr_bc, ts_frame);
      end else if (do_write) begin
        wr_addr <= aux_addr;
        wr_data <= s_axis_tdata;
      end
      // A rewind wins over the increment of a same-cycle write (bad single-beat frame).
      if (do_rewind) begin
        aux_addr <= commited_wr_address + ONE;
      end else if (do_write || do_pub) begin
        aux_addr <= aux_addr + ONE;
      end
      if (do_pub) begin
        commited_wr_address <= aux_addr;
        committed_frames    <= committed_frames + 32'd1;
      end
      if (do_drop) begin
        dropped_frames <= dropped_frames + 32'd1;
      end
      if (do_sof) begin
        beats    <= BEAT_W'(1);
        ts_frame <= ts_cnt;
      end else if (do_write) begin
        beats <= beats + BEAT_W'(1);
      end
      if (do_latch) begin
        hdr_bc  <= s_axis_tuser[TU_BC_LSB  +: 16];
        hdr_src <= s_axis_tuser[TU_SRC_LSB +: 8];
        hdr_dst <= s_axis_tuser[TU_DST_LSB +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_writer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rx_frame_writer : directed bench, ADDR_W=8, MAX_FRAME_WORDS=16 rev 1.0|
// +--------------------------------------------------------------------+
module tb_rx_frame_writer;

  localparam int AW   = 8;
  localparam int MAXW = 16;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [63:0]    tdata;
  logic [7:0]     tstrb;
  logic [127:0]   tuser;
  logic           tvalid, tlast, tready;
  logic [AW-1:0]  wr_addr;
  logic [63:0]    wr_data;
  logic           wr_en;
  logic [AW-1:0]  commit;
  logic           rd_upd;
  logic [AW-1:0]  rd_addr;
  logic [31:0]    cframes, dframes;

  int             vectors = 0;
  int             miscompares = 0;
  int unsigned    cyc = 0;
  int             wr_cnt = 0;
  logic [63:0]    mem [0:255];

  always #5 clk = ~clk;

  rx_frame_writer #(
    .ADDR_W          (AW),
    .MAX_FRAME_WORDS (MAXW)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .s_axis_tdata        (tdata),
    .s_axis_tstrb        (tstrb),
    .s_axis_tuser        (tuser),
    .s_axis_tvalid       (tvalid),
    .s_axis_tlast        (tlast),
    .s_axis_tready       (tready),
    .wr_addr             (wr_addr),
    .wr_data             (wr_data),
    .wr_en               (wr_en),
    .commited_wr_address (commit),
    .rd_addr_updated     (rd_upd),
    .commited_rd_address (rd_addr),
    .committed_frames    (cframes),
    .dropped_frames      (dframes)
  );

  // Cycle count since reset release: the expected capture timestamp.
  always @(posedge clk) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
      wr_cnt       <= wr_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk_user(input logic bad, input logic [7:0] dst,
                                           input logic [7:0] src, input logic [15:0] bc);
    logic [127:0] u;
    u         = '0;
    u[15:0]   = bc;
    u[23:16]  = src;
    u[31:24]  = dst;
    u[32]     = bad;
    return u;
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic last, input logic [127:0] u,
                           output logic [31:0] ts);
    int g;
    @(negedge clk);
    tdata  = d;
    tlast  = last;
    tuser  = u;
    tvalid = 1'b1;
    g = 0;
    while (!tready && g < 8) begin
      @(negedge clk);
      g++;
    end
    if (!tready) chk("tready_wait", 64'(tready), 64'd1);
    ts = cyc;
    @(posedge clk);
  endtask

  task automatic send_frame(input int n, input logic [63:0] base, input logic [127:0] u,
                            output logic [31:0] ts0);
    logic [31:0] t;
    ts0 = '0;
    for (int i = 0; i < n; i++) begin
      send_beat(base + 64'(i), (i == n - 1), u, t);
      if (i == 0) ts0 = t;
    end
  endtask

  task automatic release_bus();
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic finish_frame();
    release_bus();
    repeat (2) @(negedge clk);
  endtask

  logic [31:0] ts;
  int          base_wc;

  initial begin
    reset_n = 1'b0;
    tdata = '0; tstrb = 8'hFF; tuser = '0; tvalid = 1'b0; tlast = 1'b0;
    rd_upd = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_tready",  64'(tready),  64'd1);
    chk("rst_wr_en",   64'(wr_en),   64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", wr_data,      64'd0);
    chk("rst_commit",  64'(commit),  64'd0);
    chk("rst_cframes", 64'(cframes), 64'd0);
    chk("rst_dframes", 64'(dframes), 64'd0);
    reset_n = 1'b1;

    // 8-beat frame into an empty buffer
    base_wc = wr_cnt;
    send_frame(8, 64'h1000, mk_user(1'b0, 8'h02, 8'h01, 16'd60), ts);
    release_bus();
    chk("t1_tready_n1", 64'(tready),  64'd0);
    chk("t1_last_addr", 64'(wr_addr), 64'd8);
    @(negedge clk);
    chk("t1_tready_n2", 64'(tready),  64'd0);
    chk("t1_hdr_en",    64'(wr_en),   64'd1);
    chk("t1_hdr_addr",  64'(wr_addr), 64'd0);
    chk("t1_hdr_data",  wr_data,      {8'h02, 8'h01, 16'h003C, ts});
    chk("t1_commit_pre", 64'(commit), 64'd0);
    @(negedge clk);
    chk("t1_commit",  64'(commit),  64'd9);
    chk("t1_tready",  64'(tready),  64'd1);
    chk("t1_cframes", 64'(cframes), 64'd1);
    chk("t1_mem1",    mem[1],       64'h1000);
    chk("t1_mem8",    mem[8],       64'h1007);
    chk("t1_wr_cnt",  64'(wr_cnt - base_wc), 64'd9);

    // Bad frame, then a good one reusing the same slots
    base_wc = wr_cnt;
    send_frame(3, 64'h2000, mk_user(1'b1, 8'h07, 8'h08, 16'd24), ts);
    release_bus();
    chk("t2_dframes", 64'(dframes), 64'd1);
    chk("t2_tready",  64'(tready),  64'd1);
    repeat (2) @(negedge clk);
    chk("t2_commit",  64'(commit),  64'd9);
    chk("t2_wr_cnt",  64'(wr_cnt - base_wc), 64'd3);
    send_frame(2, 64'h2100, mk_user(1'b0, 8'h03, 8'h04, 16'd16), ts);
    finish_frame();
    chk("t2b_mem10",  mem[10],      64'h2100);
    chk("t2b_mem11",  mem[11],      64'h2101);
    chk("t2b_hdr",    mem[9],       {8'h03, 8'h04, 16'h0010, ts});
    chk("t2b_commit", 64'(commit),  64'd12);
    chk("t2b_cframes", 64'(cframes), 64'd2);

    // Single-beat frame
    send_frame(1, 64'h3000, mk_user(1'b0, 8'h05, 8'h06, 16'd8), ts);
    finish_frame();
    chk("t3_mem13",  mem[13],     64'h3000);
    chk("t3_hdr",    mem[12],     {8'h05, 8'h06, 16'h0008, ts});
    chk("t3_commit", 64'(commit), 64'd14);

    // 20-beat frame exceeds MAX_FRAME_WORDS = 16
    base_wc = wr_cnt;
    send_frame(20, 64'h4000, mk_user(1'b0, 8'h01, 8'h01, 16'd160), ts);
    release_bus();
    chk("t4_dframes", 64'(dframes), 64'd2);
    @(negedge clk);
    chk("t4_wr_cnt",  64'(wr_cnt - base_wc), 64'd16);
    chk("t4_mem30",   mem[30],      64'h400F);
    chk("t4_commit",  64'(commit),  64'd14);
    chk("t4_cframes", 64'(cframes), 64'd3);
    send_frame(1, 64'h4100, mk_user(1'b0, 8'h01, 8'h01, 16'd8), ts);
    finish_frame();
    chk("t4b_mem15",  mem[15],     64'h4100);
    chk("t4b_commit", 64'(commit), 64'd16);

    // Reset in the middle of a frame
    for (int i = 0; i < 3; i++) send_beat(64'h5000 + 64'(i), 1'b0, mk_user(1'b0, 8'h01, 8'h01, 16'd40), ts);
    @(negedge clk);
    tvalid  = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_tready",  64'(tready),  64'd1);
    chk("t5_wr_en",   64'(wr_en),   64'd0);
    chk("t5_wr_addr", 64'(wr_addr), 64'd0);
    chk("t5_wr_data", wr_data,      64'd0);
    chk("t5_commit",  64'(commit),  64'd0);
    chk("t5_cframes", 64'(cframes), 64'd0);
    chk("t5_dframes", 64'(dframes), 64'd0);
    reset_n = 1'b1;
    send_frame(2, 64'h5003, mk_user(1'b0, 8'h01, 8'h01, 16'd16), ts);
    finish_frame();
    chk("t5b_mem1",   mem[1],      64'h5003);
    chk("t5b_commit", 64'(commit), 64'd3);

    // Fill the buffer up to commit pointer 240 with rd_sync still 0
    for (int f = 0; f < 13; f++) begin
      send_frame(16, 64'h6000 + 64'(f * 256), mk_user(1'b0, 8'h01, 8'h01, 16'd128), ts);
      finish_frame();
    end
    send_frame(15, 64'h6F00, mk_user(1'b0, 8'h01, 8'h01, 16'd120), ts);
    finish_frame();
    chk("t6_commit",  64'(commit),  64'd240);
    chk("t6_cframes", 64'(cframes), 64'd15);

    // No room for a whole frame: dropped without writes
    base_wc = wr_cnt;
    send_frame(4, 64'h7000, mk_user(1'b0, 8'h01, 8'h01, 16'd32), ts);
    release_bus();
    chk("t7_dframes", 64'(dframes), 64'd1);
    repeat (2) @(negedge clk);
    chk("t7_wr_cnt",  64'(wr_cnt - base_wc), 64'd0);
    chk("t7_commit",  64'(commit),  64'd240);

    // Consumer advances to 200, the next frame fits
    @(negedge clk);
    rd_addr = 8'd200;
    rd_upd  = 1'b1;
    @(negedge clk);
    rd_upd  = 1'b0;
    repeat (4) @(negedge clk);
    send_frame(12, 64'h8000, mk_user(1'b0, 8'h0A, 8'h09, 16'd96), ts);
    finish_frame();
    chk("t8_mem241", mem[241],    64'h8000);
    chk("t8_mem252", mem[252],    64'h800B);
    chk("t8_hdr",    mem[240],    {8'h0A, 8'h09, 16'h0060, ts});
    chk("t8_commit", 64'(commit), 64'd253);

    // Commit pointer at 2^ADDR_W - 3 wraps through zero
    send_frame(5, 64'h9000, mk_user(1'b0, 8'h0C, 8'h0B, 16'd40), ts);
    finish_frame();
    chk("t9_mem254",  mem[254],     64'h9000);
    chk("t9_mem255",  mem[255],     64'h9001);
    chk("t9_mem0",    mem[0],       64'h9002);
    chk("t9_mem2",    mem[2],       64'h9004);
    chk("t9_hdr",     mem[253],     {8'h0C, 8'h0B, 16'h0028, ts});
    chk("t9_commit",  64'(commit),  64'd3);
    chk("t9_cframes", 64'(cframes), 64'd17);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
